// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEF_WIDTH = 16;

   function automatic int cnt_w(input int w);
      return $clog2(w) + 1;
   endfunction

   localparam int DEF_CNT_W = cnt_w(DEF_WIDTH);

endpackage

// File: rtl/sub_ripple.sv
// Ripple-borrow subtractor: i_a - i_b as i_a + ~i_b + 1 through full-adder cells.
module sub_ripple #(
   parameter int N = 17
) (
   input  logic [N-1:0] i_a,
   input  logic [N-1:0] i_b,
   output logic [N-1:0] o_diff,
   output logic         o_borrow
);

   logic [N:0]   w_c;
   logic [N-1:0] w_nb;

   assign w_nb   = ~i_b;
   assign w_c[0] = 1'b1;

   for (genvar i = 0; i < N; i++) begin : g_fa
      assign o_diff[i]  = i_a[i] ^ w_nb[i] ^ w_c[i];
      assign w_c[i + 1] = (i_a[i] & w_nb[i]) | (w_c[i] & (i_a[i] ^ w_nb[i]));
   end

   // No carry out of the top cell means the subtraction went negative.
   assign o_borrow = ~w_c[N];

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle restoring divider, one quotient bit per cycle.
// SIGNED_DIV_EN selects two's-complement operands with truncation toward zero.
import div_pkg::*;

module seq_restoring_divider #(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = cnt_w(WIDTH);

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_d;
   logic [WIDTH-1:0] r_r;
   logic [WIDTH-1:0] r_quot;
   logic [WIDTH-1:0] r_rem;
   logic [CW-1:0]    r_cnt;
   logic             r_dbz;

   logic [WIDTH:0]   w_rs;
   logic [WIDTH:0]   w_t;
   logic             w_borrow;
   logic             w_take;
   logic             w_last;
   logic             w_zero;
   logic             w_accept;
   logic [WIDTH-1:0] w_q_nxt;
   logic [WIDTH-1:0] w_r_nxt;
   logic [WIDTH-1:0] w_a_mag;
   logic [WIDTH-1:0] w_b_mag;
   logic [WIDTH-1:0] w_quot;
   logic [WIDTH-1:0] w_rem;

   assign w_rs = {r_r, r_q[WIDTH-1]};

   sub_ripple #(
      .N(WIDTH + 1)
   ) u_sub (
      .i_a     (w_rs),
      .i_b     ({1'b0, r_d}),
      .o_diff  (w_t),
      .o_borrow(w_borrow)
   );

   assign w_take   = !w_borrow && !w_t[WIDTH];
   assign w_q_nxt  = {r_q[WIDTH-2:0], w_take};
   assign w_r_nxt  = w_take ? w_t[WIDTH-1:0] : w_rs[WIDTH-1:0];
   assign w_last   = (r_cnt == CW'(WIDTH - 1));
   assign w_zero   = (divisor == '0);
   assign w_accept = in_valid && in_ready;

`ifdef SIGNED_DIV_EN
   logic r_nq;
   logic r_nr;

   assign w_a_mag = dividend[WIDTH-1] ? -dividend : dividend;
   assign w_b_mag = divisor[WIDTH-1] ? -divisor : divisor;
   // Sign fix-up lands in the same edge that enters DONE.
   assign w_quot  = r_nq ? -w_q_nxt : w_q_nxt;
   assign w_rem   = r_nr ? -w_r_nxt : w_r_nxt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_nq <= 1'b0;
         r_nr <= 1'b0;
      end else if (w_accept) begin
         r_nq <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
         r_nr <= dividend[WIDTH-1];
      end
   end
`else
   assign w_a_mag = dividend;
   assign w_b_mag = divisor;
   assign w_quot  = w_q_nxt;
   assign w_rem   = w_r_nxt;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:    if (in_valid) w_next = w_zero ? DONE : RUN;
         RUN:     if (w_last) w_next = DONE;
         DONE:    if (out_ready) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_q    <= '0;
         r_d    <= '0;
         r_r    <= '0;
         r_cnt  <= '0;
         r_quot <= '0;
         r_rem  <= '0;
         r_dbz  <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_q   <= w_a_mag;
                  r_d   <= w_b_mag;
                  r_r   <= '0;
                  r_cnt <= '0;
                  r_dbz <= w_zero;
                  if (w_zero) begin
                     r_quot <= '1;
                     r_rem  <= dividend;
                  end
               end
            end
            RUN: begin
               r_q   <= w_q_nxt;
               r_r   <= w_r_nxt;
               r_cnt <= r_cnt + 1'b1;
               if (w_last) begin
                  r_quot <= w_quot;
                  r_rem  <= w_rem;
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready    = (r_state == IDLE);
   assign out_valid   = (r_state == DONE);
   assign quotient    = r_quot;
   assign remainder   = r_rem;
   assign div_by_zero = r_dbz;

endmodule
